cte_yuv_sched: RTL
==================

# cte_yuv_sched

Stream scheduler for the CTE RGB→YUV 4:2:2 path (op_mode=1). It accepts RGB pixels under a busy handshake and issues each pixel to the external matrix datapath. It gathers the datapath results per even/odd pixel pair and emits them as the byte sequence U, Y0, V, Y1 on `yuv_out`. It sits between the CTE top-level ports and the conversion datapath, and owns all backpressure and ordering.

## Interface
- `DP_LAT`, default 2: datapath latency in cycles from `dp_valid` to valid `dp_y/dp_u/dp_v`. Legal range 0..7.
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-low reset.
- `op_mode` in 1: 1 = RGB→YUV, handled here. 0 = pixel ignored by this block.
- `in_en` in 1: input pixel strobe.
- `rgb_in` in 24: {R,G,B}, 8 bits each.
- `busy` out 1: registered. Input is not accepted while high.
- `dp_valid` out 1: registered. Pixel issued to the datapath this cycle.
- `dp_rgb` out 24: registered pixel to the datapath.
- `dp_y` in 8: unsigned luma, DP_LAT cycles after `dp_valid`.
- `dp_u` in 8: two's-complement chroma, same timing as `dp_y`.
- `dp_v` in 8: two's-complement chroma, same timing as `dp_y`.
- `out_valid` out 1: registered. `yuv_out` byte valid.
- `yuv_out` out 8: registered output byte.

## Operation
- **Accept condition:** accept = `in_en & op_mode & !busy` at a rising edge. An accepted pixel toggles the pair parity bit, which is 0 for even pixels and 1 for odd pixels.
- **Datapath issue:** `dp_valid`/`dp_rgb` register the accepted pixel and are high for exactly one cycle per accepted pixel.
- **Result tracking:** a tag shift register DP_LAT+1 deep carries {valid, parity}. Results are captured at the edge where the tag exits.
  - Even pixel: store U, Y0, V into the open slot.
  - Odd pixel: store Y1 and mark the slot full.
- **Storage:** two pair slots, ping-pong, written in order and drained in order.
- **Chroma:** U and V are taken from the even pixel only. The odd pixel's `dp_u`/`dp_v` are discarded. Values pass through unmodified, with no rounding and no sign change.
- **Serializer:** when the head slot is full and the serializer is idle, it emits U, Y0, V, Y1 on 4 consecutive cycles with `out_valid` continuously high. The slot frees after Y1. A second full slot starts on the cycle immediately after Y1, with no gap.
- **Occupancy counter `occ` (0..4, pixels accepted but not retired):**
  - +1 on accept.
  - -1 when V is emitted (even pixel retires).
  - -1 when Y1 is emitted (odd pixel retires).
  - Simultaneous accept and retire: net 0.
- **Busy rule:** `busy <= (occ_next == 4)`. `occ` never exceeds 4, and no capture ever finds its slot occupied.
- **Trailing odd pixel:** a lone even pixel at the end of a stream stays in its slot. It is never emitted until its partner arrives or reset occurs. There is no flush.
- **op_mode=0 with in_en=1:** no accept, no state change, `busy` unaffected.
- **Reset (`reset`=0 at an edge):**
  - Clears `occ`, parity, the tag register, both slots and the serializer.
  - `busy`=0, `dp_valid`=0, `dp_rgb`=0, `out_valid`=0, `yuv_out`=0.
  - Datapath results for pixels issued before reset are dropped, because their tags are cleared.
  - A group being serialized is aborted mid-sequence.

## Timing
- **Datapath issue:** pixel accepted at edge t gives `dp_valid` high in cycle (t, t+1]. Results are captured at edge t+1+DP_LAT.
- **First-byte latency:** odd pixel accepted at edge t gives `out_valid` (U) visible after edge t+2+DP_LAT, and Y1 after edge t+5+DP_LAT.
- **Steady state:** throughput is 2 pixels per 4 cycles. `busy` settles to a periodic pattern, and the stream has no bubbles once both slots are in use.
- **Busy reaction:** `busy` rises the cycle after the 4th outstanding accept and falls the cycle after a retire.
- **Sampling:** the testbench drives at negedge and samples `busy` at negedge, so a registered `busy` is sufficient.

## Structure
- **Shared package `cte_pkg`:**
  - Byte-order enum: BYTE_U, BYTE_Y0, BYTE_V, BYTE_Y1.
  - `CTE_PAIR_SLOTS`=2.
  - `CTE_OCC_MAX`=4.
  - Pair-slot struct {u, y0, v, y1, full}.
- **Sub-module `cte_yuv_ser`:** the 4-byte serializer. Inputs are the head-slot struct plus start. Outputs are `out_valid`, `yuv_out`, `v_done` and `y1_done`.
- **Top of this block:** accept logic, parity, tag pipeline, ping-pong slots and `occ`.

## Test plan
Benches use a stub datapath: `dp_y`=R, `dp_u`=G, `dp_v`=B, delayed DP_LAT cycles.

1. **Single pair:** DP_LAT=2, pixels 0x102030 then 0x405060 → `yuv_out` 0x20, 0x10, 0x30, 0x40 on 4 consecutive cycles. First byte is valid after edge t+4, where t is the second accept.
2. **Long stream:** 500-pixel stream at full rate, in_en always 1 → 1000 bytes in U, Y, V, Y order. `occ` is never greater than 4, `busy` is periodic in steady state, and no byte is lost or duplicated.
3. **Latency sweep:** DP_LAT=0 and DP_LAT=7 → same byte sequence as scenario 1. Latency is t+2+DP_LAT in both cases.
4. **Mixed op_mode:** in_en=1 with op_mode=0 on pixel 0x0A0B0C between a pair → that pixel is absent from the output and the pair is emitted unchanged.
5. **Reset mid-serialization:** `reset`=0 for one edge after the U byte is emitted → `out_valid`=0, `busy`=0, `occ`=0. A following pair 0x010203/0x040506 yields 0x02, 0x01, 0x03, 0x04 with no stale bytes.
6. **Odd trailing pixel:** 3 pixels then idle for 20 cycles → exactly 4 bytes out. The 4th pixel then completes the second group with its correct values.

Source files
------------

// File: rtl/cte_pkg.sv
`default_nettype none
// Shared types and sizing for the CTE RGB->YUV 4:2:2 scheduler.
package cte_pkg;

  typedef enum logic [1:0] {
    BYTE_U  = 2'd0,
    BYTE_Y0 = 2'd1,
    BYTE_V  = 2'd2,
    BYTE_Y1 = 2'd3
  } byte_sel_e;

  localparam int CTE_PAIR_SLOTS = 2;
  localparam int CTE_OCC_MAX    = 4;

  typedef struct packed {
    logic [7:0] u;
    logic [7:0] y0;
    logic [7:0] v;
    logic [7:0] y1;
    logic       full;
  } pair_slot_t;

endpackage
`default_nettype wire

// File: rtl/cte_yuv_ser.sv
`default_nettype none
// Four-byte serializer: emits U, Y0, V, Y1 from the head pair slot.
module cte_yuv_ser
  import cte_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  pair_slot_t head,
  input  logic       start,
  output logic       out_valid,
  output logic [7:0] yuv_out,
  output logic       v_done,
  output logic       y1_done
);

  byte_sel_e  sel;
  byte_sel_e  sel_next;
  logic       active_next;
  logic [7:0] byte_next;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sel       <= BYTE_U;
      out_valid <= 1'b0;
      yuv_out   <= '0;
    end else begin
      sel       <= sel_next;
      out_valid <= active_next;
      yuv_out   <= byte_next;
    end
  end

  // A new group may start on the edge after Y1 is shown, so back-to-back groups have no gap.
  always_comb begin
    sel_next    = BYTE_U;
    active_next = 1'b0;
    if (out_valid && (sel != BYTE_Y1)) begin
      active_next = 1'b1;
      sel_next    = byte_sel_e'(sel + 2'd1);
    end else if (start) begin
      active_next = 1'b1;
      sel_next    = BYTE_U;
    end
  end

  always_comb begin
    byte_next = '0;
    if (active_next) begin
      case (sel_next)
        BYTE_U:  byte_next = head.u;
        BYTE_Y0: byte_next = head.y0;
        BYTE_V:  byte_next = head.v;
        BYTE_Y1: byte_next = head.y1;
      endcase
    end
    v_done  = active_next && (sel_next == BYTE_V);
    y1_done = active_next && (sel_next == BYTE_Y1);
  end

endmodule
`default_nettype wire

// File: rtl/cte_yuv_sched.sv
`default_nettype none
// RGB->YUV 4:2:2 stream scheduler: accept/busy, datapath issue, result tags, pair slots.
module cte_yuv_sched
  import cte_pkg::*;
#(
  parameter int DP_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_mode,
  input  logic        in_en,
  input  logic [23:0] rgb_in,
  output logic        busy,
  output logic        dp_valid,
  output logic [23:0] dp_rgb,
  input  logic [7:0]  dp_y,
  input  logic [7:0]  dp_u,
  input  logic [7:0]  dp_v,
  output logic        out_valid,
  output logic [7:0]  yuv_out
);

  localparam int TW = DP_LAT + 1;

  logic          accept;
  logic          parity;
  logic [2:0]    occ;
  logic [2:0]    occ_next;
  logic [TW-1:0] tag_v;
  logic [TW-1:0] tag_p;
  logic          cap;
  logic          cap_odd;
  logic          wr_ptr;
  logic          rd_ptr;
  logic          v_done;
  logic          y1_done;
  pair_slot_t    slots [CTE_PAIR_SLOTS];
  pair_slot_t    head;

  assign accept   = in_en & op_mode & ~busy;
  assign cap      = tag_v[DP_LAT];
  assign cap_odd  = tag_p[DP_LAT];
  assign head     = slots[rd_ptr];
  assign occ_next = occ + 3'(accept) - 3'(v_done) - 3'(y1_done);

  always_ff @(posedge clk) begin
    if (!reset) begin
      parity   <= 1'b0;
      occ      <= '0;
      busy     <= 1'b0;
      dp_valid <= 1'b0;
      dp_rgb   <= '0;
      tag_v    <= '0;
      tag_p    <= '0;
    end else begin
      if (accept) begin
        parity <= ~parity;
        dp_rgb <= rgb_in;
      end
      occ      <= occ_next;
      busy     <= (occ_next == 3'(CTE_OCC_MAX));
      dp_valid <= accept;
      // Tag carries the pre-toggle parity, so 0 marks the even pixel of a pair.
      tag_v    <= (tag_v << 1) | TW'(accept);
      tag_p    <= (tag_p << 1) | TW'(parity);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < CTE_PAIR_SLOTS; i++) slots[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (y1_done) begin
        slots[rd_ptr].full <= 1'b0;
        rd_ptr             <= ~rd_ptr;
      end
      if (cap && !cap_odd) begin
        slots[wr_ptr].u  <= dp_u;
        slots[wr_ptr].y0 <= dp_y;
        slots[wr_ptr].v  <= dp_v;
      end
      if (cap && cap_odd) begin
        slots[wr_ptr].y1   <= dp_y;
        slots[wr_ptr].full <= 1'b1;
        wr_ptr             <= ~wr_ptr;
      end
    end
  end

  cte_yuv_ser u_ser (
    .clk       (clk),
    .reset     (reset),
    .head      (head),
    .start     (head.full),
    .out_valid (out_valid),
    .yuv_out   (yuv_out),
    .v_done    (v_done),
    .y1_done   (y1_done)
  );

endmodule
`default_nettype wire
